// File: rtl/bp_be_fcsr_accum_pkg.sv
// Shared types and CSR addresses for the FP flag accumulator: the fflags record
// and the three FP CSR addresses the block responds to.
package bp_be_fcsr_accum_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } bp_be_fflags_s;

    localparam logic [11:0] bp_be_csr_fflags_addr_gp = 12'h001;
    localparam logic [11:0] bp_be_csr_frm_addr_gp    = 12'h002;
    localparam logic [11:0] bp_be_csr_fcsr_addr_gp   = 12'h003;

    localparam logic [2:0] bp_be_frm_rne_gp = 3'd0;

    // Encodings 5..7 are reserved for the architectural rounding mode.
    function automatic logic bp_be_frm_reserved(input logic [2:0] frm);
        return (frm > 3'd4);
    endfunction

endpackage

// File: rtl/bp_be_fflags_pipe.sv
// Valid+flags shift register from FP flag capture to commit. Stage 0 is the live
// input; stages 1..depth-1 are registered, so a depth of 1 commits combinationally.
module bp_be_fflags_pipe
    import bp_be_fcsr_accum_pkg::*;
#(
    parameter int pipe_depth_p = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          v_i,
    input  bp_be_fflags_s flags_i,
    output logic          v_o,
    output bp_be_fflags_s flags_o
);

    logic          [pipe_depth_p-1:0] vld_pipe;
    bp_be_fflags_s [pipe_depth_p-1:0] flags_pipe;

    assign vld_pipe[0]   = v_i;
    assign flags_pipe[0] = flags_i;

    generate
        if (pipe_depth_p > 1) begin : g_regs
            logic          [pipe_depth_p-1:1] vld_r;
            bp_be_fflags_s [pipe_depth_p-1:1] flags_r;

            // Flush drops every stage, including the live input about to be captured.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    vld_r   <= '0;
                    flags_r <= '0;
                end else begin
                    for (int i = 1; i < pipe_depth_p; i++) begin
                        vld_r[i]   <= vld_pipe[i-1] & ~flush_i;
                        flags_r[i] <= flags_pipe[i-1];
                    end
                end
            end

            assign vld_pipe[pipe_depth_p-1:1]   = vld_r;
            assign flags_pipe[pipe_depth_p-1:1] = flags_r;
        end
    endgenerate

    assign v_o     = vld_pipe[pipe_depth_p-1];
    assign flags_o = flags_pipe[pipe_depth_p-1];

endmodule

// File: rtl/bp_be_fcsr_accum.sv
// FP CSR owner: accumulates retiring ops' fflags, holds frm for the FP pipe,
// serves fflags/frm/fcsr reads and writes, and tracks FS-dirty.
module bp_be_fcsr_accum
    import bp_be_fcsr_accum_pkg::*;
#(
    parameter int pipe_depth_p = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fp_v_i,
    input  logic [4:0]  fflags_i,
    input  logic        flush_i,
    output logic [2:0]  frm_o,
    output logic        frm_invalid_o,
    input  logic        csr_w_v_i,
    input  logic [11:0] csr_addr_i,
    input  logic [7:0]  csr_wdata_i,
    output logic [7:0]  csr_rdata_o,
    output logic        commit_v_o,
    output logic        dirty_o,
    input  logic        dirty_clr_i
);

    bp_be_fflags_s pipe_flags;
    logic          pipe_v;

    bp_be_fflags_pipe #(.pipe_depth_p(pipe_depth_p)) pipe (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .v_i     (fp_v_i),
        .flags_i (bp_be_fflags_s'(fflags_i)),
        .v_o     (pipe_v),
        .flags_o (pipe_flags)
    );

    bp_be_fflags_s fflags_r, fflags_n, commit_flags;
    logic [2:0]    frm_r, frm_n;
    logic          dirty_r, dirty_n;
    logic          hit_fflags, hit_frm, is_fcsr;

    assign commit_v_o   = pipe_v & ~flush_i;
    assign commit_flags = commit_v_o ? pipe_flags : '0;

    assign is_fcsr    = (csr_addr_i == bp_be_csr_fcsr_addr_gp);
    assign hit_fflags = csr_w_v_i & ((csr_addr_i == bp_be_csr_fflags_addr_gp) | is_fcsr);
    assign hit_frm    = csr_w_v_i & ((csr_addr_i == bp_be_csr_frm_addr_gp) | is_fcsr);

    // The committing op is younger than a same-cycle CSR write, so its flags
    // are ORed on top of the written value.
    always_comb begin
        fflags_n = (hit_fflags ? bp_be_fflags_s'(csr_wdata_i[4:0]) : fflags_r) | commit_flags;
        frm_n    = frm_r;
        if (hit_frm)
            frm_n = is_fcsr ? csr_wdata_i[7:5] : csr_wdata_i[2:0];
        dirty_n  = dirty_r;
        if (hit_fflags | hit_frm | (|commit_flags))
            dirty_n = 1'b1;
        else if (dirty_clr_i)
            dirty_n = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fflags_r <= '0;
            frm_r    <= bp_be_frm_rne_gp;
            dirty_r  <= 1'b0;
        end else begin
            fflags_r <= fflags_n;
            frm_r    <= frm_n;
            dirty_r  <= dirty_n;
        end
    end

    // Reads see only current register state; no bypass of same-cycle updates.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            bp_be_csr_fflags_addr_gp: csr_rdata_o = {3'b000, fflags_r};
            bp_be_csr_frm_addr_gp:    csr_rdata_o = {5'b00000, frm_r};
            bp_be_csr_fcsr_addr_gp:   csr_rdata_o = {frm_r, fflags_r};
            default:                  csr_rdata_o = '0;
        endcase
    end

    assign frm_o         = frm_r;
    assign frm_invalid_o = bp_be_frm_reserved(frm_r);
    assign dirty_o       = dirty_r;

endmodule

// File: tb/tb_bp_be_fcsr_accum.sv
// Scoreboard bench: a queue-of-ops reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the design.
module tb_bp_be_fcsr_accum;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_i, fp_v_i, flush_i, csr_w_v_i, dirty_clr_i;
    logic [4:0]  fflags_i;
    logic [11:0] csr_addr_i;
    logic [7:0]  csr_wdata_i;
    logic [2:0]  frm_o;
    logic        frm_invalid_o, commit_v_o, dirty_o;
    logic [7:0]  csr_rdata_o;

    bp_be_fcsr_accum #(.pipe_depth_p(DEPTH)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .fp_v_i        (fp_v_i),
        .fflags_i      (fflags_i),
        .flush_i       (flush_i),
        .frm_o         (frm_o),
        .frm_invalid_o (frm_invalid_o),
        .csr_w_v_i     (csr_w_v_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .commit_v_o    (commit_v_o),
        .dirty_o       (dirty_o),
        .dirty_clr_i   (dirty_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       commit;
        logic [7:0] rdata;
        logic [2:0] frm;
        logic       inv;
        logic       dirty;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [4:0] fl;
        int         due;
    } op_t;

    exp_t       expq[$];
    op_t        pend[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [4:0] m_ff;
    logic [2:0] m_frm;
    logic       m_dirty;

    task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, c, act, req);
        end
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("commit_v", e.cyc, {7'b0, commit_v_o}, {7'b0, e.commit});
            chk("rdata", e.cyc, csr_rdata_o, e.rdata);
            chk("frm", e.cyc, {5'b0, frm_o}, {5'b0, e.frm});
            chk("frm_invalid", e.cyc, {7'b0, frm_invalid_o}, {7'b0, e.inv});
            chk("dirty", e.cyc, {7'b0, dirty_o}, {7'b0, e.dirty});
        end
    end

    // Drive one cycle and advance the reference model.
    task automatic step(input logic v, input logic [4:0] fl, input logic fsh,
                        input logic w, input logic [11:0] a, input logic [7:0] wd,
                        input logic clr, input logic rst);
        exp_t       e;
        logic       due_now, hit_ff, hit_frm;
        logic [4:0] cfl;
        @(posedge clk);
        #1;
        reset_i = rst; fp_v_i = v; fflags_i = fl; flush_i = fsh;
        csr_w_v_i = w; csr_addr_i = a; csr_wdata_i = wd; dirty_clr_i = clr;
        if (rst) begin
            pend.delete();
            m_ff = '0; m_frm = '0; m_dirty = 1'b0;
        end
        due_now  = !rst && pend.size() > 0 && pend[0].due == cyc;
        e.commit = due_now && !fsh;
        case (a)
            12'h001: e.rdata = {3'b0, m_ff};
            12'h002: e.rdata = {5'b0, m_frm};
            12'h003: e.rdata = {m_frm, m_ff};
            default: e.rdata = 8'h00;
        endcase
        e.frm   = m_frm;
        e.inv   = (m_frm >= 3'd5);
        e.dirty = m_dirty;
        e.cyc   = cyc;
        expq.push_back(e);
        if (!rst) begin
            hit_ff  = w && (a == 12'h001 || a == 12'h003);
            hit_frm = w && (a == 12'h002 || a == 12'h003);
            cfl     = e.commit ? pend[0].fl : 5'h00;
            m_ff    = (hit_ff ? wd[4:0] : m_ff) | cfl;
            if (hit_frm) m_frm = (a == 12'h003) ? wd[7:5] : wd[2:0];
            if (hit_ff || hit_frm || cfl != 5'h00) m_dirty = 1'b1;
            else if (clr) m_dirty = 1'b0;
            if (fsh) pend.delete();
            else if (due_now) void'(pend.pop_front());
            if (v && !fsh) pend.push_back('{fl: fl, due: cyc + DEPTH - 1});
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [11:0] a);
        for (int i = 0; i < n; i++) step(1'b0, 5'h00, 1'b0, 1'b0, a, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic op(input logic [4:0] fl, input logic [11:0] a);
        step(1'b1, fl, 1'b0, 1'b0, a, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] wd);
        step(1'b0, 5'h00, 1'b0, 1'b1, a, wd, 1'b0, 1'b0);
    endtask

    initial begin
        logic [11:0] a;
        reset_i = 1'b1; fp_v_i = 1'b0; fflags_i = '0; flush_i = 1'b0;
        csr_w_v_i = 1'b0; csr_addr_i = 12'h001; csr_wdata_i = '0; dirty_clr_i = 1'b0;
        m_ff = '0; m_frm = '0; m_dirty = 1'b0;
        repeat (2) @(posedge clk);

        // reset arriving while an op is in flight
        op(5'h01, 12'h001);
        step(1'b0, 5'h00, 1'b0, 1'b0, 12'h001, 8'h00, 1'b0, 1'b1);
        step(1'b0, 5'h00, 1'b0, 1'b0, 12'h001, 8'h00, 1'b0, 1'b1);
        idle(5, 12'h001);

        // single op, then three accumulating ops
        op(5'h10, 12'h001);
        idle(5, 12'h001);
        op(5'h01, 12'h001); op(5'h04, 12'h001); op(5'h10, 12'h001);
        idle(5, 12'h001);

        // flush kills the op in its commit cycle; next op commits normally
        step(1'b1, 5'h08, 1'b0, 1'b0, 12'h003, 8'h00, 1'b1, 1'b0);
        idle(2, 12'h003);
        step(1'b0, 5'h00, 1'b1, 1'b0, 12'h003, 8'h00, 1'b0, 1'b0);
        op(5'h02, 12'h003);
        idle(5, 12'h003);

        // fcsr write colliding with a commit
        wr(12'h001, 8'h00);
        op(5'h04, 12'h003);
        idle(2, 12'h003);
        wr(12'h003, 8'hE3);
        idle(3, 12'h003);

        // field isolation and dirty clear
        wr(12'h003, 8'h5F);
        wr(12'h002, 8'h02);
        idle(1, 12'h003);
        wr(12'h001, 8'h00);
        idle(1, 12'h003);
        step(1'b0, 5'h00, 1'b0, 1'b0, 12'h003, 8'h00, 1'b1, 1'b0);
        idle(2, 12'h002);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0: a = 12'h001;
                1: a = 12'h002;
                2: a = 12'h003;
                3: a = 12'h000;
                default: a = 12'($urandom);
            endcase
            step($urandom_range(0, 1) == 1, 5'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                 a, 8'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 199) == 0);
        end
        idle(DEPTH + 2, 12'h003);

        repeat (3) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending records want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
